// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the memory-mapped UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_ACTIVE = 3;
  localparam int STAT_CNT_LO = 4;
  localparam int STAT_CNT_HI = 8;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - core data-bus slice seen by the UART register window
interface uart_tx_mmio_if #(
  parameter int LENGTH = 32
);

  logic [LENGTH-1:0] HADDR;
  logic [LENGTH-1:0] HWDATA;
  logic              MemWrite;
  logic              sel;
  logic [LENGTH-1:0] rdata;

  modport master (
    output HADDR, HWDATA, MemWrite,
    input  sel, rdata
  );

  modport slave (
    input  HADDR, HWDATA, MemWrite,
    output sel, rdata
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous power-of-two FIFO buffering bytes ahead of the serialiser
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - store-decoded UART transmitter: register window, overflow flag, 8N1 serialiser
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int                LENGTH     = 32,
  parameter logic [LENGTH-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int                CLK_DIV    = 434,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           tx_busy
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  tx_state_t         state;
  logic [15:0]       baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              overflow;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        fifo_dout;
  logic              push;
  logic              pop;
  logic              wr_txdata;
  logic              wr_status;
  logic              baud_last;
  logic [LENGTH-1:0] status_word;
  logic              unused_bits;

  assign bus.sel   = (bus.HADDR[LENGTH-1:3] == BASE_ADDR[LENGTH-1:3]);
  assign wr_txdata = bus.sel & bus.MemWrite & (bus.HADDR[2] == TXDATA_OFS[2]);
  assign wr_status = bus.sel & bus.MemWrite & (bus.HADDR[2] == STATUS_OFS[2]);
  assign push      = wr_txdata & ~fifo_full;
  assign baud_last = (baud_cnt == BAUD_LAST);
  // Pop in IDLE or on the last STOP cycle so frames chain with no idle gap.
  assign pop       = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_last));
  assign tx_busy   = ~fifo_empty | (state != ST_IDLE);
  assign unused_bits = ^{bus.HWDATA[LENGTH-1:8], bus.HADDR[1:0]};

  always_comb begin
    status_word                           = '0;
    status_word[STAT_FULL]                = fifo_full;
    status_word[STAT_EMPTY]               = fifo_empty;
    status_word[STAT_OVF]                 = overflow;
    status_word[STAT_ACTIVE]              = (state != ST_IDLE);
    status_word[STAT_CNT_HI:STAT_CNT_LO]  = 5'(fifo_count);
  end

  assign bus.rdata = (bus.sel && (bus.HADDR[2] == STATUS_OFS[2])) ? status_word : '0;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (bus.HWDATA[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A dropped push sets overflow even if a clear arrives on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_txdata & fifo_full) begin
      overflow <= 1'b1;
    end else if (wr_status & bus.HWDATA[2]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shreg    <= fifo_dout;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shreg <= fifo_dout;
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              tx    <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          DIV  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tx;
  logic tx_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  uart_tx_mmio_if #(.LENGTH(32)) bus ();

  uart_tx_mmio #(
    .LENGTH     (32),
    .BASE_ADDR  (BASE),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.HADDR    = addr;
    bus.HWDATA   = data;
    bus.MemWrite = 1'b1;
    @(negedge clock);
    bus.MemWrite = 1'b0;
    bus.HADDR    = 32'h0;
    bus.HWDATA   = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.HADDR = BASE + 32'h4;
    #1;
    v = bus.rdata;
  endtask

  // Called on the first start-bit cycle; returns on the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * DIV; k++) begin
      check($sformatf("%s_c%0d", tag, k), {31'b0, tx}, {31'b0, bits[k / DIV]});
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] st;
    int          cycles;
    logic        saw_low;

    vecs[0]  = '{BASE + 32'h4,     32'h0,  1'b0, 1'b1, 32'h002};
    vecs[1]  = '{BASE + 32'h0,     32'h0,  1'b0, 1'b1, 32'h000};
    vecs[2]  = '{BASE + 32'h7,     32'h0,  1'b0, 1'b1, 32'h002};
    vecs[3]  = '{BASE + 32'h8,     32'h0,  1'b0, 1'b0, 32'h000};
    vecs[4]  = '{BASE - 32'h4,     32'h0,  1'b0, 1'b0, 32'h000};
    vecs[5]  = '{BASE + 32'h100,   32'h55, 1'b1, 1'b0, 32'h000};
    vecs[6]  = '{BASE + 32'h104,   32'h0,  1'b0, 1'b0, 32'h000};
    vecs[7]  = '{BASE + 32'h4,     32'h0,  1'b0, 1'b1, 32'h002};
    vecs[8]  = '{BASE + 32'h4,     32'h4,  1'b1, 1'b1, 32'h002};
    vecs[9]  = '{BASE + 32'h4,     32'h0,  1'b0, 1'b1, 32'h002};
    vecs[10] = '{32'h9000_0004,    32'h0,  1'b0, 1'b0, 32'h000};

    bus.HADDR    = 32'h0;
    bus.HWDATA   = 32'h0;
    bus.MemWrite = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_tx", {31'b0, tx}, 32'h1);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("idle_tx", {31'b0, tx}, 32'h1);
    check("idle_busy", {31'b0, tx_busy}, 32'h0);
    read_status(st);
    check("idle_status", st, 32'h002);
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      bus.HADDR    = vecs[i].addr;
      bus.HWDATA   = vecs[i].wdata;
      bus.MemWrite = vecs[i].we;
      #1;
      check($sformatf("vec%0d_sel", i), {31'b0, bus.sel}, {31'b0, vecs[i].exp_sel});
      check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      @(negedge clock);
    end
    bus.MemWrite = 1'b0;
    bus.HADDR    = 32'h0;
    #1;
    check("vec_nopush_busy", {31'b0, tx_busy}, 32'h0);
    @(negedge clock);

    // Single frame 0xA5.
    bus_write(BASE, 32'hA5);
    check("a5_pre_tx", {31'b0, tx}, 32'h1);
    read_status(st);
    check("a5_status_queued", st, 32'h010);
    @(negedge clock);
    read_status(st);
    check("a5_status_active", st, 32'h00A);
    check_frame(8'hA5, "a5");
    check("a5_end_tx", {31'b0, tx}, 32'h1);
    check("a5_end_busy", {31'b0, tx_busy}, 32'h0);
    repeat (3) @(negedge clock);

    // Back-to-back frames with no idle gap.
    bus_write(BASE, 32'h01);
    bus_write(BASE, 32'h80);
    check_frame(8'h01, "b2b_01");
    check_frame(8'h80, "b2b_80");
    check("b2b_end_tx", {31'b0, tx}, 32'h1);
    check("b2b_end_busy", {31'b0, tx_busy}, 32'h0);
    repeat (3) @(negedge clock);

    // Overflow: six consecutive writes, one popped, four queued, one dropped.
    for (int i = 0; i < 6; i++) begin
      bus_write(BASE, 32'h10 + i);
    end
    read_status(st);
    check("ovf_status", st, 32'h04D);
    bus_write(BASE + 32'h4, 32'h4);
    read_status(st);
    check("ovf_cleared", st, 32'h049);
    cycles = 0;
    while (tx_busy && cycles < 400) begin
      @(negedge clock);
      cycles++;
    end
    check("ovf_drain_cycles", cycles, 195);
    read_status(st);
    check("ovf_final_status", st, 32'h002);
    repeat (3) @(negedge clock);

    // Reset asserted mid-DATA with one byte still queued.
    bus_write(BASE, 32'h3C);
    bus_write(BASE, 32'hC3);
    repeat (8) @(negedge clock);
    read_status(st);
    check("mid_status", st, 32'h018);
    check("mid_tx", {31'b0, tx}, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_mid_tx", {31'b0, tx}, 32'h1);
    check("rst_mid_busy", {31'b0, tx_busy}, 32'h0);
    check("rst_mid_status", bus.rdata, 32'h002);
    @(negedge clock);
    reset = 1'b1;
    saw_low = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (!tx || tx_busy) saw_low = 1'b1;
    end
    check("post_rst_quiet", {31'b0, saw_low}, 32'h0);
    read_status(st);
    check("post_rst_status", st, 32'h002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
